// File: rtl/ram_arbiter_if.sv
// Bundle of the two requester ports and the single RAM port shared by ram_arbiter.
// The slave view is taken by the arbiter; the master view belongs to requesters and the RAM.
interface ram_arbiter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req0;
    logic             we0;
    logic             lock0;
    logic [WIDTH-1:0] addr0;
    logic [WIDTH-1:0] wdata0;
    logic             gnt0;
    logic             rvalid0;
    logic [WIDTH-1:0] rdata0;

    logic             req1;
    logic             we1;
    logic             lock1;
    logic [WIDTH-1:0] addr1;
    logic [WIDTH-1:0] wdata1;
    logic             gnt1;
    logic             rvalid1;
    logic [WIDTH-1:0] rdata1;

    logic [WIDTH-1:0] ramaddress;
    logic [WIDTH-1:0] writeramdata;
    logic             writeram;
    logic [WIDTH-1:0] readramdata;

    modport slave (
        input  req0, we0, lock0, addr0, wdata0,
        output gnt0, rvalid0, rdata0,
        input  req1, we1, lock1, addr1, wdata1,
        output gnt1, rvalid1, rdata1,
        output ramaddress, writeramdata, writeram,
        input  readramdata
    );

    modport master (
        output req0, we0, lock0, addr0, wdata0,
        input  gnt0, rvalid0, rdata0,
        output req1, we1, lock1, addr1, wdata1,
        input  gnt1, rvalid1, rdata1,
        input  ramaddress, writeramdata, writeram,
        output readramdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port data RAM: round-robin or fixed priority,
// optional locked bursts capped at MAXBURST, and registered read return with a valid strobe.
module ram_arbiter #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned FIXED_PRIO = 0,
    parameter int unsigned MAXBURST   = 8
) (
    input  logic          clock,
    input  logic          nreset,
    ram_arbiter_if.slave  bus
);
    localparam int unsigned CW = $clog2(MAXBURST + 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_0    = 2'd1,
        OWN_1    = 2'd2
    } owner_e;

    owner_e           owner_q, owner_d;
    logic [CW-1:0]    burstcnt_q, burstcnt_d;
    logic             last_q, last_d;
    logic             hand_q, hand_d;
    logic             hand_port_q, hand_port_d;
    logic             rvalid0_q, rvalid1_q;
    logic [WIDTH-1:0] rdata0_q, rdata1_q;

    logic             gnt0_c, gnt1_c, pick1_c;
    logic             gport_c, glock_c;
    owner_e           gown_c;
    int unsigned      cnt_next_c;

    // A burst that just hit its cap hands the next tie to the other port, whatever the priority mode.
    always_comb begin
        pick1_c = 1'b0;
        gnt0_c  = 1'b0;
        gnt1_c  = 1'b0;
        if (hand_q) begin
            pick1_c = ~hand_port_q;
        end else if (FIXED_PRIO != 0) begin
            pick1_c = 1'b0;
        end else begin
            pick1_c = ~last_q;
        end
        if (nreset) begin
            if (owner_q == OWN_0 && bus.req0) begin
                gnt0_c = 1'b1;
            end else if (owner_q == OWN_1 && bus.req1) begin
                gnt1_c = 1'b1;
            end else if (bus.req0 && bus.req1) begin
                gnt0_c = ~pick1_c;
                gnt1_c = pick1_c;
            end else begin
                gnt0_c = bus.req0;
                gnt1_c = bus.req1;
            end
        end
    end

    // Ownership/burst bookkeeping; a count inherited from the other port's burst restarts at zero.
    always_comb begin
        owner_d     = OWN_NONE;
        burstcnt_d  = '0;
        last_d      = last_q;
        hand_d      = 1'b0;
        hand_port_d = hand_port_q;
        gport_c     = gnt1_c;
        gown_c      = gnt1_c ? OWN_1 : OWN_0;
        glock_c     = gnt1_c ? bus.lock1 : bus.lock0;
        cnt_next_c  = 32'd1;
        if (owner_q == gown_c) begin
            cnt_next_c = 32'(burstcnt_q) + 32'd1;
        end
        if (gnt0_c || gnt1_c) begin
            last_d = gport_c;
            if (glock_c && cnt_next_c < MAXBURST) begin
                owner_d    = gown_c;
                burstcnt_d = CW'(cnt_next_c);
            end else if (glock_c) begin
                hand_d      = 1'b1;
                hand_port_d = gport_c;
            end
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            owner_q     <= OWN_NONE;
            burstcnt_q  <= '0;
            last_q      <= 1'b1;
            hand_q      <= 1'b0;
            hand_port_q <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            burstcnt_q  <= burstcnt_d;
            last_q      <= last_d;
            hand_q      <= hand_d;
            hand_port_q <= hand_port_d;
        end
    end

    // RAM pins follow the granted port and rest at zero otherwise.
    always_comb begin
        bus.ramaddress   = '0;
        bus.writeramdata = '0;
        bus.writeram     = 1'b0;
        if (gnt0_c) begin
            bus.ramaddress   = bus.addr0;
            bus.writeramdata = bus.wdata0;
            bus.writeram     = bus.we0;
        end else if (gnt1_c) begin
            bus.ramaddress   = bus.addr1;
            bus.writeramdata = bus.wdata1;
            bus.writeram     = bus.we1;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= gnt0_c & ~bus.we0;
            rvalid1_q <= gnt1_c & ~bus.we1;
            if (gnt0_c && !bus.we0) begin
                rdata0_q <= bus.readramdata;
            end
            if (gnt1_c && !bus.we1) begin
                rdata1_q <= bus.readramdata;
            end
        end
    end

    assign bus.gnt0    = gnt0_c;
    assign bus.gnt1    = gnt1_c;
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single data RAM port between two requesters:
  - port 0: the RISC-V core data interface;
  - port 1: a secondary master, e.g. the JPEG input loader / debug DMA.
- Sits between the requesters and the RAM's address/wdata/enw/rdata pins.
- Round-robin or fixed-priority arbitration, with optional locked bursts.
- Registered read-data return with a one-cycle valid strobe per port.

Parameters:
- WIDTH, 32, data and address width.
- FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins ties.
- MAXBURST, 8, maximum consecutive locked grants to one port before forced hand-over (range 1..255).

Ports:
- clock  input  1  system clock, rising edge.
- nreset  input  1  asynchronous active-low reset.
- req0  input  1  port 0 access request.
- we0  input  1  port 0 write (1) / read (0).
- lock0  input  1  port 0 requests to keep ownership next cycle.
- addr0  input  WIDTH  port 0 word address.
- wdata0  input  WIDTH  port 0 write data.
- gnt0  output  1  port 0 access accepted this cycle.
- rvalid0  output  1  rdata0 valid (read granted previous cycle).
- rdata0  output  WIDTH  port 0 registered read data.
- req1, we1, lock1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1.
- ramaddress  output  WIDTH  RAM address.
- writeramdata  output  WIDTH  RAM write data.
- writeram  output  1  RAM write enable.
- readramdata  input  WIDTH  RAM read data, combinational from ramaddress.

Behaviour:
- Reset (async, nreset=0):
  - owner=NONE, burstcnt=0, last=1 (port 0 wins first tie).
  - rvalid0/1=0, rdata0/1=0.
  - gnt0/1=0, writeram=0, ramaddress=0, writeramdata=0.
  - Reset mid-burst drops ownership immediately; no RAM write occurs while nreset=0.
- Grant logic is combinational from registered state and the current req inputs. At most one gnt is high per cycle.
- State machine (owner): NONE, OWN0, OWN1.
  - NONE:
    - Single requester: that port is granted.
    - Both requesting, round-robin: grant the port != last.
    - Both requesting, FIXED_PRIO=1: grant port 0.
  - OWNn:
    - If reqn=1, port n is granted unconditionally (other port stalls).
    - If reqn=0, ownership is released this cycle and arbitration proceeds as in NONE.
- Ownership update at a clock edge where port n is granted:
  - lockn=1 and burstcnt+1 < MAXBURST: owner<=OWNn, burstcnt<=burstcnt+1.
  - Otherwise: owner<=NONE, burstcnt<=0.
  - If burstcnt reaches MAXBURST and the other port is requesting, the other port wins the next cycle regardless of the round-robin pointer.
  - If the other port is idle, the same port may be regranted, starting a new burst with burstcnt=1.
- Pointer: last<=n on every cycle where gnt to port n is high.
- Datapath:
  - ramaddress/writeramdata take the granted port's addr/wdata.
  - writeram = gnt & we of the granted port. The write commits at that rising edge.
  - No grant: ramaddress=0, writeramdata=0, writeram=0.
- Read return, latency 1:
  - At the edge of a granted read on port n: rdatan<=readramdata, rvalidn<=1.
  - Otherwise rvalidn<=0 and rdatan holds its last value.
  - Writes never raise rvalid.
- Requester rules:
  - Hold req/we/addr/wdata stable until gnt is seen.
  - Deasserting req without a grant is legal: the request is simply withdrawn, with no side effects.
- Simultaneous events:
  - lock asserted without req is ignored.
  - Both ports locking: round-robin still alternates at every burst end.
- Wrap: burstcnt is a ceil(log2(MAXBURST+1))-bit counter. It never exceeds MAXBURST-1 in the register.

Test Plan:
- Reset, then port 0 read only: req0=1, we0=0, addr0=5, RAM[5]=0xDEADBEEF → gnt0=1 same cycle; next cycle rvalid0=1, rdata0=0xDEADBEEF, gnt1=0 throughout.
- Tie, round-robin: req0=req1=1 held 4 cycles, no lock → grants 0,1,0,1; last toggles each cycle; each read's rvalid pulses exactly one cycle after its grant.
- Locked burst: MAXBURST=4, port 1 lock1=1 req1=1 continuously, req0=1 → gnt1 for 4 cycles, then gnt0 for 1 cycle, then port 1 again; no cycle with both gnt high.
- Write path: port 0 writes 0x12345678 to addr 9 while port 1 reads addr 9 → order follows grant order; a read granted after the write returns 0x12345678; writeram high only in the write's grant cycle.
- FIXED_PRIO=1: both request 3 cycles, no lock → gnt0 all 3 cycles, gnt1=0; after req0 drops, gnt1 the same cycle.
- Async reset mid-burst: drop nreset during OWN1 with burstcnt=2 → gnt*/writeram/rvalid* go 0 immediately without a clock; after release, a tie grants port 0 first.
